// File: rtl/nes_bus_pkg.sv
// Shared NES CPU-bus definitions: arbiter state encodings
// and the OAM DMA register addresses.
package nes_bus_pkg;

    typedef enum logic [1:0] {
        ARB_CPU  = 2'b00,
        ARB_HALT = 2'b01,
        ARB_DMA  = 2'b10
    } arb_state_t;

    localparam logic [15:0] REG_OAMDMA  = 16'h4014;
    localparam logic [15:0] REG_OAMDATA = 16'h2004;

endpackage

// File: rtl/cpu_bus_arbiter_if.sv
// Sprite-DMA request/grant link between the OAM-DMA master and the
// CPU bus arbiter.
//   spr_req    master->slave  bus request (registered in requester)
//   spr_gnt    slave->master  transfer completes this cycle
//   spr_addr   master->slave  DMA address
//   spr_wn     master->slave  DMA write-not (0 = write)
//   spr_wdata  master->slave  DMA write data
//   spr_rdata  slave->master  read data, valid when spr_gnt
interface cpu_bus_arbiter_if;

    logic        spr_req;
    logic        spr_gnt;
    logic [15:0] spr_addr;
    logic        spr_wn;
    logic [7:0]  spr_wdata;
    logic [7:0]  spr_rdata;

    modport master (
        output spr_req,
        output spr_addr,
        output spr_wn,
        output spr_wdata,
        input  spr_gnt,
        input  spr_rdata
    );

    modport slave (
        input  spr_req,
        input  spr_addr,
        input  spr_wn,
        input  spr_wdata,
        output spr_gnt,
        output spr_rdata
    );

endinterface

// File: rtl/cpu_bus_arbiter.sv
// CPU-side bus arbiter: halts the 6502 through RDY while the sprite
// DMA owns the 16-bit bus, granting on get/put cycle parity.
// Ports:
//   i_clk, i_rst            clock (one CPU cycle), sync active-high reset
//   i_cpu_addr/wn/wdata     CPU bus request
//   o_cpu_rdata, o_cpu_rdy  CPU read data and RDY (0 = halted)
//   spr                     DMA req/gnt link (slave side)
//   o_bus_addr/wn/wdata     shared bus drive
//   i_bus_rdata             shared bus read data (combinational)
//   o_dma_active            high whenever the arbiter is not in ARB_CPU
module cpu_bus_arbiter
    import nes_bus_pkg::*;
#(
    parameter bit ALIGN_EN = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [15:0] i_cpu_addr,
    input  logic        i_cpu_wn,
    input  logic [7:0]  i_cpu_wdata,
    output logic [7:0]  o_cpu_rdata,
    output logic        o_cpu_rdy,
    cpu_bus_arbiter_if.slave spr,
    output logic [15:0] o_bus_addr,
    output logic        o_bus_wn,
    output logic [7:0]  o_bus_wdata,
    input  logic [7:0]  i_bus_rdata,
    output logic        o_dma_active
);

    arb_state_t r_state;
    arb_state_t w_next;
    logic       r_put;
    logic       w_dma_own;
    logic       w_halt;
    logic       w_par_ok;
    logic       w_gnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ARB_CPU;
            r_put   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_put   <= ~r_put;
        end
    end

    // CPU write cycles cannot be halted on a 6502, so the request
    // only takes effect on a CPU read cycle.
    always_comb begin
        w_next    = ARB_CPU;
        o_cpu_rdy = 1'b1;
        case (r_state)
            ARB_CPU: begin
                o_cpu_rdy = ~(spr.spr_req & i_cpu_wn);
                if (spr.spr_req & i_cpu_wn) begin
                    w_next = ARB_HALT;
                end
            end
            ARB_HALT: begin
                o_cpu_rdy = 1'b0;
                w_next    = ARB_DMA;
            end
            ARB_DMA: begin
                o_cpu_rdy = ~spr.spr_req;
                if (spr.spr_req) begin
                    w_next = ARB_DMA;
                end
            end
            default: begin
                o_cpu_rdy = 1'b1;
                w_next    = ARB_CPU;
            end
        endcase
    end

    // Reads complete on get cycles, writes on put cycles.
    assign w_par_ok  = ~ALIGN_EN | (spr.spr_wn ? ~r_put : r_put);
    assign w_dma_own = (r_state == ARB_DMA) & spr.spr_req;
    assign w_halt    = (r_state == ARB_HALT);
    assign w_gnt     = w_dma_own & w_par_ok;

    // A DMA write only reaches the bus on its grant cycle; alignment
    // idles and the halt cycle are dummy reads.
    assign o_bus_addr  = w_dma_own ? spr.spr_addr : i_cpu_addr;
    assign o_bus_wdata = w_dma_own ? spr.spr_wdata : i_cpu_wdata;
    assign o_bus_wn    = w_dma_own ? (spr.spr_wn | ~w_gnt)
                                   : (w_halt | i_cpu_wn);

    assign spr.spr_gnt   = w_gnt;
    assign spr.spr_rdata = i_bus_rdata;
    assign o_cpu_rdata   = i_bus_rdata;
    assign o_dma_active  = (r_state != ARB_CPU);

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Bench: two arbiters (aligned / unaligned) driven by a CPU stream and
// a behavioural OAM-DMA master, checked per cycle and per DMA run.
module tb_cpu_bus_arbiter;
    import nes_bus_pkg::*;

    typedef struct packed {
        logic [15:0] a;
        logic        wn;
        logic [7:0]  d;
    } op_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        rst_at_edge;
    logic [15:0] cpu_addr  [2];
    logic        cpu_wn    [2];
    logic [7:0]  cpu_wdata [2];
    logic [7:0]  cpu_rdata [2];
    logic        cpu_rdy   [2];
    logic [15:0] bus_addr  [2];
    logic        bus_wn    [2];
    logic [7:0]  bus_wdata [2];
    logic [7:0]  bus_rdata [2];
    logic        act       [2];
    logic        req       [2];
    logic        gnt       [2];
    logic [15:0] spr_addr  [2];
    logic        spr_wn    [2];
    logic [7:0]  spr_wdata [2];
    logic [7:0]  srd       [2];

    int total = 0;
    int bad = 0;
    int tc = 0;
    bit force_req = 1'b0;

    int       n       [2];
    logic [7:0] page  [2];
    logic [7:0] latch [2];
    bit       pend    [2];
    bit       restart [2];
    int       abort_at[2];
    bit       rdy_s   [2];
    bit       g_s     [2];
    logic [7:0] rd_s  [2];
    bit       rec     [2];
    bit       trig    [2];
    int       cyc     [2];
    int       low     [2];
    int       stall   [2];
    int       gcnt    [2];
    int       lat     [2];
    int       fp      [2];
    int       wb      [2];
    int       exp_wb  [2];
    int       exp_g   [2];
    int       done    [2];

    op_t q0[$];
    op_t q1[$];

    cpu_bus_arbiter_if sif0 ();
    cpu_bus_arbiter_if sif1 ();

    assign sif0.spr_req   = req[0];
    assign sif0.spr_addr  = spr_addr[0];
    assign sif0.spr_wn    = spr_wn[0];
    assign sif0.spr_wdata = spr_wdata[0];
    assign gnt[0]         = sif0.spr_gnt;
    assign srd[0]         = sif0.spr_rdata;
    assign sif1.spr_req   = req[1];
    assign sif1.spr_addr  = spr_addr[1];
    assign sif1.spr_wn    = spr_wn[1];
    assign sif1.spr_wdata = spr_wdata[1];
    assign gnt[1]         = sif1.spr_gnt;
    assign srd[1]         = sif1.spr_rdata;

    function automatic logic [7:0] memf(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    assign bus_rdata[0] = memf(bus_addr[0]);
    assign bus_rdata[1] = memf(bus_addr[1]);

    cpu_bus_arbiter #(.ALIGN_EN(1'b1)) dut0 (
        .i_clk(clk), .i_rst(rst),
        .i_cpu_addr(cpu_addr[0]), .i_cpu_wn(cpu_wn[0]),
        .i_cpu_wdata(cpu_wdata[0]), .o_cpu_rdata(cpu_rdata[0]),
        .o_cpu_rdy(cpu_rdy[0]), .spr(sif0.slave),
        .o_bus_addr(bus_addr[0]), .o_bus_wn(bus_wn[0]),
        .o_bus_wdata(bus_wdata[0]), .i_bus_rdata(bus_rdata[0]),
        .o_dma_active(act[0])
    );

    cpu_bus_arbiter #(.ALIGN_EN(1'b0)) dut1 (
        .i_clk(clk), .i_rst(rst),
        .i_cpu_addr(cpu_addr[1]), .i_cpu_wn(cpu_wn[1]),
        .i_cpu_wdata(cpu_wdata[1]), .o_cpu_rdata(cpu_rdata[1]),
        .o_cpu_rdy(cpu_rdy[1]), .spr(sif1.slave),
        .o_bus_addr(bus_addr[1]), .o_bus_wn(bus_wn[1]),
        .o_bus_wdata(bus_wdata[1]), .i_bus_rdata(bus_rdata[1]),
        .o_dma_active(act[1])
    );

    task automatic chk(input string tag, input int d,
                       input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s[%0d] observed=%0h expected=%0h",
                   tag, d, obs, exp);
        end
    endtask

    function automatic op_t next_op(input int d);
        op_t op;
        if (d == 0 && q0.size() > 0) begin
            op = q0.pop_front();
        end else if (d == 1 && q1.size() > 0) begin
            op = q1.pop_front();
        end else begin
            op.a  = 16'($urandom_range(0, 2047));
            op.wn = 1'($urandom_range(0, 1));
            op.d  = 8'($urandom);
        end
        return op;
    endfunction

    task automatic push(input logic [15:0] a, input logic wn,
                        input logic [7:0] dat);
        op_t op;
        op.a  = a;
        op.wn = wn;
        op.d  = dat;
        q0.push_back(op);
        q1.push_back(op);
    endtask

    task automatic drive();
        op_t op;
        if (rst_at_edge) tc = 0;
        else tc++;
        for (int d = 0; d < 2; d++) begin
            if (rst_at_edge) begin
                req[d] = 1'b0;
                pend[d] = 1'b0;
                restart[d] = 1'b0;
                rec[d] = 1'b0;
                trig[d] = 1'b0;
                n[d] = 0;
            end else begin
                if (g_s[d]) begin
                    if (n[d] % 2 == 0) latch[d] = rd_s[d];
                    n[d]++;
                end
                if (req[d] && abort_at[d] >= 0 && n[d] == abort_at[d]) begin
                    req[d] = 1'b0;
                    restart[d] = 1'b1;
                    abort_at[d] = -1;
                end else if (req[d] && n[d] >= 512) begin
                    req[d] = 1'b0;
                end else if (!req[d] && (pend[d] || restart[d])) begin
                    if (restart[d]) page[d] = page[d] + 8'd1;
                    req[d] = 1'b1;
                    n[d] = 0;
                    pend[d] = 1'b0;
                    restart[d] = 1'b0;
                end
            end
            if (force_req) req[d] = 1'b1;
            spr_addr[d]  = (n[d] % 2 == 1) ? REG_OAMDATA
                                           : {page[d], 8'(n[d] >> 1)};
            spr_wn[d]    = (n[d] % 2 == 0);
            spr_wdata[d] = latch[d];
            if (rdy_s[d]) begin
                op = next_op(d);
                cpu_addr[d]  = op.a;
                cpu_wn[d]    = op.wn;
                cpu_wdata[d] = op.d;
            end
        end
    endtask

    task automatic sample();
        logic [15:0] ea;
        for (int d = 0; d < 2; d++) begin
            rdy_s[d] = cpu_rdy[d];
            g_s[d]   = gnt[d];
            rd_s[d]  = bus_rdata[d];
            chk("cpu_rdata", d, 32'(cpu_rdata[d]), 32'(bus_rdata[d]));
            if (!act[d]) begin
                chk("own_addr", d, 32'(bus_addr[d]), 32'(cpu_addr[d]));
                chk("own_wn", d, 32'(bus_wn[d]), 32'(cpu_wn[d]));
                chk("own_wd", d, 32'(bus_wdata[d]), 32'(cpu_wdata[d]));
                chk("idle_gnt", d, 32'(gnt[d]), 32'(0));
                if (!cpu_wn[d])
                    chk("wr_rdy", d, 32'(cpu_rdy[d]), 32'(1));
            end else if (!bus_wn[d]) begin
                chk("stray_wr", d, 32'({gnt[d], bus_addr[d]}),
                    32'({1'b1, REG_OAMDATA}));
            end
            if (gnt[d]) begin
                ea = (n[d] % 2 == 1) ? REG_OAMDATA
                                     : {page[d], 8'(n[d] >> 1)};
                chk("gnt_addr", d, 32'(bus_addr[d]), 32'(ea));
                chk("gnt_wn", d, 32'(bus_wn[d]), 32'(n[d] % 2 == 0));
                chk("spr_rdata", d, 32'(srd[d]), 32'(memf(ea)));
                if (n[d] % 2 == 1)
                    chk("gnt_wd", d, 32'(bus_wdata[d]), 32'(latch[d]));
                if (d == 0)
                    chk("gnt_par", d, 32'(tc % 2), 32'(n[d] % 2));
            end
            if (!act[d] && !bus_wn[d] && bus_addr[d] == REG_OAMDMA &&
                !req[d] && !pend[d] && !restart[d]) begin
                pend[d] = 1'b1;
                page[d] = bus_wdata[d];
                trig[d] = 1'b1;
                wb[d] = 0;
            end
            if (trig[d] && !act[d] && !bus_wn[d]) wb[d]++;
            if (!cpu_rdy[d] && !rec[d]) begin
                rec[d] = 1'b1;
                cyc[d] = -1;
                low[d] = 0;
                stall[d] = 0;
                gcnt[d] = 0;
                lat[d] = 0;
                fp[d] = tc % 2;
                chk("halt_on_rd", d, 32'(cpu_wn[d]), 32'(1));
                if (trig[d])
                    chk("wr_unstall", d, 32'(wb[d]), 32'(exp_wb[d]));
                trig[d] = 1'b0;
            end
            if (rec[d]) begin
                cyc[d]++;
                if (!cpu_rdy[d]) low[d]++;
                if (!cpu_rdy[d] && act[d]) stall[d]++;
                if (gnt[d]) begin
                    gcnt[d]++;
                    if (gcnt[d] == 1) lat[d] = cyc[d];
                end
                if (act[d] && cpu_rdy[d]) begin
                    chk("rel_gnt", d, 32'(gnt[d]), 32'(0));
                    chk("rel_addr", d, 32'(bus_addr[d]), 32'(cpu_addr[d]));
                    chk("rel_wn", d, 32'(bus_wn[d]), 32'(cpu_wn[d]));
                    chk("gnt_count", d, 32'(gcnt[d]), 32'(exp_g[d]));
                    chk("rdy_low", d, 32'(low[d]), 32'(stall[d] + 1));
                    if (exp_g[d] == 512)
                        chk("stall", d, 32'(stall[d]),
                            32'(d == 0 ? 513 + fp[d] : 513));
                    chk("latency", d, 32'(lat[d]),
                        32'(d == 0 ? 2 + fp[d] : 2));
                    rec[d] = 1'b0;
                    done[d]++;
                    exp_g[d] = 512;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        rst_at_edge = rst;
        #1;
        drive();
        @(negedge clk);
        sample();
    endtask

    task automatic wait_done(input int t, input int budget);
        int k = 0;
        while ((done[0] < t || done[1] < t) && k < budget) begin
            tick();
            k++;
        end
        total++;
        assert (done[0] >= t && done[1] >= t) else begin
            bad++;
            $error("FAIL dma_timeout observed=%0d/%0d expected=%0d",
                   done[0], done[1], t);
        end
    endtask

    task automatic dma(input logic [7:0] pg, input int nwr,
                       input int abort, input int runs);
        push(REG_OAMDMA, 1'b0, pg);
        for (int i = 0; i < nwr; i++)
            push(16'($urandom_range(0, 2047)), 1'b0, 8'($urandom));
        push(16'($urandom_range(0, 2047)), 1'b1, 8'h00);
        for (int d = 0; d < 2; d++) begin
            exp_wb[d] = 1 + nwr;
            abort_at[d] = abort;
            exp_g[d] = (abort >= 0) ? abort : 512;
        end
        wait_done(done[0] + runs, 1200 * runs);
    endtask

    initial begin
        int k;
        rst = 1'b1;
        rst_at_edge = 1'b1;
        force_req = 1'b1;
        for (int d = 0; d < 2; d++) begin
            n[d] = 0; page[d] = 8'h00; latch[d] = 8'h00;
            pend[d] = 0; restart[d] = 0; abort_at[d] = -1;
            rdy_s[d] = 1; g_s[d] = 0; rd_s[d] = 8'h00;
            rec[d] = 0; trig[d] = 0; done[d] = 0;
            exp_wb[d] = 1; exp_g[d] = 512;
            cyc[d] = 0; low[d] = 0; stall[d] = 0; gcnt[d] = 0;
            lat[d] = 0; fp[d] = 0; wb[d] = 0;
        end
        for (int i = 0; i < 10; i++)
            push(16'($urandom_range(0, 2047)), 1'b0, 8'($urandom));
        drive();
        repeat (3) tick();
        for (int d = 0; d < 2; d++) begin
            chk("rst_rdy", d, 32'(cpu_rdy[d]), 32'(1));
            chk("rst_gnt", d, 32'(gnt[d]), 32'(0));
            chk("rst_act", d, 32'(act[d]), 32'(0));
        end
        rst = 1'b0;
        tick();
        for (int d = 0; d < 2; d++) begin
            chk("rel_rdy", d, 32'(cpu_rdy[d]), 32'(1));
            chk("rel_act", d, 32'(act[d]), 32'(0));
        end
        chk("rel_put", 0, 32'(dut0.r_put), 32'(tc % 2));
        force_req = 1'b0;
        req[0] = 1'b0;
        req[1] = 1'b0;
        repeat (10) tick();

        dma(8'h02, 0, -1, 1);
        repeat (5) tick();
        dma(8'h03, 3, -1, 1);
        repeat (7) tick();
        dma(8'h04, 0, 10, 2);
        for (int i = 0; i < 3; i++) begin
            repeat ($urandom_range(1, 9)) tick();
            dma(8'($urandom_range(0, 7)), 0, -1, 1);
        end

        push(REG_OAMDMA, 1'b0, 8'h05);
        push(16'h0123, 1'b1, 8'h00);
        k = 0;
        while ((gcnt[0] < 20 || gcnt[1] < 20 || !rec[0] || !rec[1])
               && k < 200) begin
            tick();
            k++;
        end
        chk("mid_dma_reach", 0, 32'(k < 200), 32'(1));
        rst = 1'b1;
        tick();
        for (int d = 0; d < 2; d++) begin
            chk("mrst_rdy", d, 32'(cpu_rdy[d]), 32'(1));
            chk("mrst_gnt", d, 32'(gnt[d]), 32'(0));
            chk("mrst_act", d, 32'(act[d]), 32'(0));
        end
        chk("mrst_put", 0, 32'(dut0.r_put), 32'(0));
        chk("mrst_put", 1, 32'(dut1.r_put), 32'(0));
        rst = 1'b0;
        repeat (4) tick();
        chk("post_act", 0, 32'(act[0]), 32'(0));
        chk("post_act", 1, 32'(act[1]), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
